// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//   32-bit iterative integer divider for the RV32M DIV/DIVU/REM/REMU family.
//   Restoring radix-2 algorithm: one quotient bit per cycle, MSB first, so a
//   normal operation takes 32 CALC cycles followed by a one-cycle DONE.
//
//   Signed operations are run on magnitudes; the signs are re-applied when the
//   final result is registered. Divide-by-zero and signed overflow fall out of
//   the normal iteration with the required RV32M results. The only extra rule
//   is that the quotient is never negated for a zero divisor.
//
// Ports
//   clk_i     in   1   clock, all state updates on the rising edge
//   rst_ni    in   1   synchronous active-low reset
//   start_i   in   1   request, honoured only in IDLE
//   op_i      in   2   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1       in  32   dividend, captured on acceptance
//   rs2       in  32   divisor, captured on acceptance
//   busy_o    out  1   high from the cycle after acceptance through done_o
//   done_o    out  1   one-cycle pulse, data_out valid in that cycle
//   data_out  out 32   quotient or remainder, held until the next result
//
// Configuration
//   DIV_EARLY_OUT_EN  when defined, divide-by-zero and signed overflow skip
//                     CALC and go IDLE->DONE with the result one cycle after
//                     acceptance. When undefined there is no bypass logic.
//
// States
//   state | meaning
//   IDLE  | waiting for start_i
//   CALC  | one restoring iteration per cycle, 32 cycles
//   DONE  | result presented on data_out, done_o pulsed
// -----------------------------------------------------------------------------
module div_unit (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] data_out
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state_q, state_d;

  logic [5:0]  count_q;
  logic [31:0] rem_q;      // partial remainder
  logic [31:0] quo_q;      // dividend shifts out the top, quotient shifts in
  logic [31:0] divisor_q;  // divisor magnitude
  logic        op_rem_q;
  logic        neg_quo_q;
  logic        neg_rem_q;
  logic [31:0] data_q;

  logic        accept;
  logic        last_iter;
  logic        op_signed;
  logic [31:0] mag_rs1;
  logic [31:0] mag_rs2;

  logic [32:0] trial_a;
  logic [32:0] trial_b;
  logic [32:0] trial;
  logic [31:0] rem_nx;
  logic [31:0] quo_nx;
  logic [31:0] result;

  assign accept    = (state_q == IDLE) && start_i;
  assign last_iter = (state_q == CALC) && (count_q == 6'd31);
  assign op_signed = ~op_i[0];
  assign mag_rs1   = (op_signed && rs1[31]) ? (~rs1 + 32'd1) : rs1;
  assign mag_rs2   = (op_signed && rs2[31]) ? (~rs2 + 32'd1) : rs2;

`ifdef DIV_EARLY_OUT_EN
  logic        special;
  logic [31:0] special_result;

  // Divide-by-zero wins over overflow; they cannot both hold anyway.
  always_comb begin
    special        = 1'b0;
    special_result = 32'd0;
    if (rs2 == 32'd0) begin
      special        = 1'b1;
      special_result = op_i[1] ? rs1 : 32'hFFFF_FFFF;
    end else if (op_signed && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF)) begin
      special        = 1'b1;
      special_result = op_i[1] ? 32'd0 : 32'h8000_0000;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
`ifdef DIV_EARLY_OUT_EN
          state_d = special ? DONE : CALC;
`else
          state_d = CALC;
`endif
        end
      end
      CALC: begin
        busy_o = 1'b1;
        if (count_q == 6'd31) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // One restoring step. The remainder is always below the divisor, so the
  // shifted trial value is below twice the divisor and the 33-bit difference
  // lies in (-2^32, 2^32): bit 32 is a reliable borrow/sign flag.
  // ---------------------------------------------------------------------------
  always_comb begin
    trial_a = {rem_q, quo_q[31]};
    trial_b = {1'b0, divisor_q};
    trial   = trial_a + ~trial_b + 33'd1;
    if (!trial[32]) begin
      rem_nx = trial[31:0];
      quo_nx = {quo_q[30:0], 1'b1};
    end else begin
      rem_nx = trial_a[31:0];
      quo_nx = {quo_q[30:0], 1'b0};
    end
  end

  // Sign fix-up applied to the values produced by the final iteration.
  always_comb begin
    if (op_rem_q) begin
      result = neg_rem_q ? (~rem_nx + 32'd1) : rem_nx;
    end else begin
      result = neg_quo_q ? (~quo_nx + 32'd1) : quo_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q   <= 6'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      divisor_q <= 32'd0;
      op_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (accept) begin
      count_q   <= 6'd0;
      rem_q     <= 32'd0;
      quo_q     <= mag_rs1;
      divisor_q <= mag_rs2;
      op_rem_q  <= op_i[1];
      // A zero divisor must leave the all-ones quotient unnegated.
      neg_quo_q <= op_signed && (rs1[31] ^ rs2[31]) && (rs2 != 32'd0);
      neg_rem_q <= op_signed && rs1[31];
    end else if (state_q == CALC) begin
      count_q <= count_q + 6'd1;
      rem_q   <= rem_nx;
      quo_q   <= quo_nx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q <= 32'd0;
`ifdef DIV_EARLY_OUT_EN
    end else if (accept && special) begin
      data_q <= special_result;
`endif
    end else if (last_iter) begin
      data_q <= result;
    end
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk_i   = 1'b0;
  logic        rst_ni  = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i    = 2'b00;
  logic [31:0] rs1     = 32'd0;
  logic [31:0] rs2     = 32'd0;
  logic        busy_o;
  logic        done_o;
  logic [31:0] data_out;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

`ifdef DIV_EARLY_OUT_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 33;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] exp_q[$];
  int          due_q[$];

  div_unit dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (start_i),
    .op_i     (op_i),
    .rs1      (rs1),
    .rs2      (rs2),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .data_out (data_out)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done_o pulse must match the oldest expected result and cycle.
  always @(negedge clk_i) begin
    if (done_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", {31'd0, done_o}, 32'd0);
      end else begin
        logic [31:0] e;
        int          d;
        e = exp_q.pop_front();
        d = due_q.pop_front();
        check("result", data_out, e);
        check("done_cycle", cyc, d);
      end
    end
  end

  task automatic expect_result(input logic [31:0] e, input int due);
    exp_q.push_back(e);
    due_q.push_back(due);
  endtask

  task automatic drain(input int limit);
    for (int n = 0; n < limit; n++) begin
      @(negedge clk_i);
      if (exp_q.size() == 0) break;
    end
    check("drain", exp_q.size(), 32'd0);
  endtask

  // Issue one operation, scramble the inputs afterwards, count busy cycles.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e, input int lat);
    int bc;
    bc = 0;
    @(posedge clk_i); #1;
    op_i = op; rs1 = a; rs2 = b; start_i = 1'b1;
    expect_result(e, cyc + lat);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    op_i = 2'($urandom);
    rs1  = $urandom;
    rs2  = $urandom;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk_i);
      if (busy_o) bc++;
      if (done_o) break;
    end
    check({name, "_done_seen"}, {31'd0, done_o}, 32'd1);
    check({name, "_busy_cycles"}, bc, lat);
    @(negedge clk_i);
    check({name, "_hold"}, data_out, e);
  endtask

  initial begin
    int t0;

    // Reset, with start asserted during reset (must be ignored).
    start_i = 1'b1; op_i = OP_DIVU; rs1 = 32'd100; rs2 = 32'd7;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    check("reset_done", {31'd0, done_o}, 32'd0);
    check("reset_data", data_out, 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1; start_i = 1'b0;
    @(negedge clk_i);
    check("post_reset_idle", {31'd0, busy_o}, 32'd0);

    // Normal-path vectors.
    run_op("divu_100_7",   OP_DIVU, 32'd100,        32'd7,          32'd14,         33);
    run_op("remu_100_7",   OP_REMU, 32'd100,        32'd7,          32'd2,          33);
    run_op("div_m7_2",     OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33);
    run_op("rem_m7_2",     OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33);
    run_op("div_7_m2",     OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33);
    run_op("rem_7_m2",     OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33);
    run_op("div_m100_m7",  OP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         33);
    run_op("rem_m100_m7",  OP_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  33);
    run_op("div_zero_dvd", OP_DIV,  32'd0,          32'd5,          32'd0,          33);
    run_op("rem_zero_dvd", OP_REM,  32'd0,          32'd5,          32'd0,          33);
    run_op("divu_max_1",   OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33);
    run_op("remu_max_16",  OP_REMU, 32'hFFFF_FFFF,  32'd16,         32'd15,         33);
    run_op("divu_ovf_ops", OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33);
    run_op("remu_ovf_ops", OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33);

    // Special cases: divide by zero and signed overflow.
    run_op("divu_by0",     OP_DIVU, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  SPEC_LAT);
    run_op("remu_by0",     OP_REMU, 32'h1234_5678,  32'd0,          32'h1234_5678,  SPEC_LAT);
    run_op("div_by0",      OP_DIV,  32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  SPEC_LAT);
    run_op("rem_m7_by0",   OP_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  SPEC_LAT);
    run_op("div_ovf",      OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  SPEC_LAT);
    run_op("rem_ovf",      OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          SPEC_LAT);

    // Start held high: ignored while busy and in DONE, next accept at T+34.
    @(posedge clk_i); #1;
    op_i = OP_DIVU; rs1 = 32'd9; rs2 = 32'd3; start_i = 1'b1;
    t0 = cyc;
    expect_result(32'd3, t0 + 33);
    expect_result(32'd3, t0 + 34 + 33);
    repeat (34) @(posedge clk_i);
    #1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    drain(80);

    // Input changes and a second start while busy must not disturb the op.
    @(posedge clk_i); #1;
    op_i = OP_DIVU; rs1 = 32'd50; rs2 = 32'd5; start_i = 1'b1;
    t0 = cyc;
    expect_result(32'd10, t0 + 33);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    rs1 = 32'd1234;
    repeat (5) @(posedge clk_i);
    #1;
    rs1 = 32'd9; rs2 = 32'd3; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    drain(60);

    // Reset mid-operation: first op aborted, restart right after release.
    @(posedge clk_i); #1;
    op_i = OP_DIVU; rs1 = 32'd100; rs2 = 32'd7; start_i = 1'b1;
    t0 = cyc;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (14) @(posedge clk_i);
    #1;
    rst_ni = 1'b0; start_i = 1'b1;
    @(posedge clk_i); #1;
    rst_ni = 1'b1; start_i = 1'b1; op_i = OP_DIVU; rs1 = 32'd9; rs2 = 32'd3;
    expect_result(32'd3, t0 + 49);
    @(negedge clk_i);
    check("midreset_busy", {31'd0, busy_o}, 32'd0);
    check("midreset_done", {31'd0, done_o}, 32'd0);
    check("midreset_data", data_out, 32'd0);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    drain(60);

    repeat (3) @(posedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
